// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizes, frame layout and loader states
// for the CNN parameter loader.
package cnn_pkg;

    localparam int DATA_W    = 8;
    localparam int N_TAPS    = 9;
    localparam int N_CELLS   = 16;
    localparam int FRAME_LEN = 2*N_TAPS + 2*N_CELLS;

    localparam int OFF_A = 0;
    localparam int OFF_B = N_TAPS;
    localparam int OFF_U = 2*N_TAPS;
    localparam int OFF_I = 2*N_TAPS + N_CELLS;

    localparam int ADDR_W = $clog2(FRAME_LEN);
    localparam int CNT_W  = $clog2(FRAME_LEN + 2);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        SETTLE
    } state_t;

endpackage

// File: rtl/cnn_param_bank.sv
// cnn_param_bank: FRAME_LEN x DATA_W shadow register file,
// one indexed byte write port, full parallel read.
module cnn_param_bank
    import cnn_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    output logic [FRAME_LEN*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [FRAME_LEN];

    // Indexed byte write; whole bank cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Flatten the bank, slot j at bits [(j+1)*DATA_W-1 : j*DATA_W]
    always_comb begin
        rdata = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            rdata[i*DATA_W +: DATA_W] = mem[i];
        end
    end

endmodule

// File: rtl/cnn_param_loader.sv
// cnn_param_loader: assembles A/B/U/I frames from a byte stream and commits
// them atomically to the array. Optional trailing checksum: CNN_LOADER_CHECKSUM_EN.
module cnn_param_loader
    import cnn_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_last,
    output logic [N_TAPS*DATA_W-1:0]  a_tmpl,
    output logic [N_TAPS*DATA_W-1:0]  b_tmpl,
    output logic [N_CELLS*DATA_W-1:0] u_in,
    output logic [N_CELLS*DATA_W-1:0] i_bias,
    output logic                      params_valid,
    output logic                      commit_pulse,
    output logic                      settle_busy,
    output logic                      frame_err
);

`ifdef CNN_LOADER_CHECKSUM_EN
    localparam int TOTAL = FRAME_LEN + 1;
`else
    localparam int TOTAL = FRAME_LEN;
`endif

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [15:0]                 scnt;
    logic                        rdy_en;
    logic                        pv;
    logic [FRAME_LEN*DATA_W-1:0] shadow;
    logic [FRAME_LEN*DATA_W-1:0] active;
    logic                        acc;
    logic                        at_end;
    logic                        wr;
    logic                        chk_ok;

    assign s_ready      = rdy_en && (state == IDLE || state == LOAD);
    assign acc          = s_valid && s_ready;
    assign at_end       = (cnt == CNT_W'(TOTAL - 1));
    assign wr           = acc && (cnt < CNT_W'(FRAME_LEN));
    assign settle_busy  = (state == SETTLE);
    assign params_valid = pv;

    assign a_tmpl = active[OFF_B*DATA_W-1     : OFF_A*DATA_W];
    assign b_tmpl = active[OFF_U*DATA_W-1     : OFF_B*DATA_W];
    assign u_in   = active[OFF_I*DATA_W-1     : OFF_U*DATA_W];
    assign i_bias = active[FRAME_LEN*DATA_W-1 : OFF_I*DATA_W];

    cnn_param_bank u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr),
        .addr  (cnt[ADDR_W-1:0]),
        .wdata (s_data),
        .rdata (shadow)
    );

`ifdef CNN_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    // Running mod-256 sum of the payload, restarted on the first byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (acc) begin
            sum <= (state == IDLE) ? s_data : sum + s_data;
        end
    end

    assign chk_ok = (sum == s_data);
`else
    assign chk_ok = 1'b1;
`endif

    // Frame sequencing, atomic commit and settle hold-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            scnt         <= '0;
            rdy_en       <= 1'b0;
            active       <= '0;
            pv           <= 1'b0;
            commit_pulse <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rdy_en       <= 1'b1;
            commit_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        if (s_last) begin
                            frame_err <= 1'b1;
                        end else begin
                            frame_err <= 1'b0;
                            cnt       <= CNT_W'(1);
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (acc) begin
                        if (s_last && at_end && chk_ok) begin
                            cnt   <= '0;
                            state <= COMMIT;
                        end else if (s_last || at_end) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    active       <= shadow;
                    commit_pulse <= 1'b1;
                    pv           <= 1'b1;
                    scnt         <= '0;
                    state        <= SETTLE;
                end
                SETTLE: begin
                    if (scnt == 16'(SETTLE_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        scnt <= scnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_param_loader.sv
// tb_cnn_param_loader: table-driven frames with random payloads checked
// against a frame-level model of the active bank.
module tb_cnn_param_loader;
    import cnn_pkg::*;

`ifdef CNN_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int L  = FRAME_LEN + (CHK ? 1 : 0);
    localparam int SC = 64;

    typedef logic [7:0] frame_t [64];
    typedef struct {
        string name;
        int    n;
        int    last_at;
        bit    gaps;
        bit    bad_chk;
        bit    exp_commit;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      s_valid = 1'b0;
    logic                      s_ready;
    logic [7:0]                s_data = '0;
    logic                      s_last = 1'b0;
    logic [N_TAPS*DATA_W-1:0]  a_tmpl;
    logic [N_TAPS*DATA_W-1:0]  b_tmpl;
    logic [N_CELLS*DATA_W-1:0] u_in;
    logic [N_CELLS*DATA_W-1:0] i_bias;
    logic                      params_valid;
    logic                      commit_pulse;
    logic                      settle_busy;
    logic                      frame_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_act [FRAME_LEN];
    logic       exp_pv = 1'b0;

    always #5 clk = ~clk;

    cnn_param_loader #(.SETTLE_CYCLES(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .a_tmpl       (a_tmpl),
        .b_tmpl       (b_tmpl),
        .u_in         (u_in),
        .i_bias       (i_bias),
        .params_valid (params_valid),
        .commit_pulse (commit_pulse),
        .settle_busy  (settle_busy),
        .frame_err    (frame_err)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic check_bank(input string nm);
        logic [127:0] ea, eb, eu, ei;
        ea = '0; eb = '0; eu = '0; ei = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            ea[k*8 +: 8] = exp_act[k];
            eb[k*8 +: 8] = exp_act[N_TAPS + k];
        end
        for (int k = 0; k < N_CELLS; k++) begin
            eu[k*8 +: 8] = exp_act[2*N_TAPS + k];
            ei[k*8 +: 8] = exp_act[2*N_TAPS + N_CELLS + k];
        end
        check({nm, " a_tmpl"}, 128'(a_tmpl), ea);
        check({nm, " b_tmpl"}, 128'(b_tmpl), eb);
        check({nm, " u_in"}, 128'(u_in), eu);
        check({nm, " i_bias"}, 128'(i_bias), ei);
        check({nm, " params_valid"}, 128'(params_valid), 128'(exp_pv));
    endtask

    // mode 0 random, 1 ramp 1..50, 2 all 0x05; checksum byte appended
    task automatic fill_frame(output frame_t f, input int mode, input bit bad);
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < 64; i++) f[i] = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            case (mode)
                1:       f[i] = 8'(i + 1);
                2:       f[i] = 8'h05;
                default: f[i] = 8'($urandom);
            endcase
            sum = sum + f[i];
        end
        f[FRAME_LEN] = sum + (bad ? 8'd1 : 8'd0);
    endtask

    task automatic put_byte(input logic [7:0] d, input bit last, input bit gaps);
        int g;
        if (gaps) begin
            g = $urandom_range(0, 3);
            repeat (g) @(negedge clk);
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        g = 0;
        while (!s_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall_timeout: s_ready stuck low for %0d cycles", g);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int n, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            put_byte(f[i], (i + 1) == last_at, gaps);
        end
    endtask

    // Called #1 after the final byte's handshake edge
    task automatic check_commit(input string nm, input frame_t f, input bit exp_commit);
        int busy, lo, pulses;
        if (exp_commit) begin
            check({nm, " pre_pulse"}, 128'(commit_pulse), 128'(0));
            check({nm, " pre_ready"}, 128'(s_ready), 128'(0));
            check({nm, " err_clear"}, 128'(frame_err), 128'(0));
            check_bank({nm, " pre"});
            for (int i = 0; i < FRAME_LEN; i++) exp_act[i] = f[i];
            exp_pv = 1'b1;
            @(posedge clk);
            #1;
            check({nm, " pulse"}, 128'(commit_pulse), 128'(1));
            check_bank({nm, " post"});
            busy = 0;
            lo = 1;
            pulses = 0;
            while (settle_busy && busy < 200) begin
                busy++;
                if (!s_ready) lo++;
                if (commit_pulse) pulses++;
                @(posedge clk);
                #1;
            end
            check({nm, " settle_len"}, 128'(busy), 128'(SC));
            check({nm, " stall_len"}, 128'(lo), 128'(SC + 1));
            check({nm, " pulse_cnt"}, 128'(pulses), 128'(1));
            check({nm, " ready_after"}, 128'(s_ready), 128'(1));
        end else begin
            check({nm, " err_set"}, 128'(frame_err), 128'(1));
            check({nm, " idle_ready"}, 128'(s_ready), 128'(1));
            check_bank({nm, " kept"});
            pulses = 0;
            repeat (70) begin
                @(posedge clk);
                #1;
                if (commit_pulse) pulses++;
            end
            check({nm, " no_pulse"}, 128'(pulses), 128'(0));
            check_bank({nm, " kept_late"});
        end
    endtask

    task automatic check_reset(input string nm);
        for (int i = 0; i < FRAME_LEN; i++) exp_act[i] = '0;
        exp_pv = 1'b0;
        check_bank(nm);
        check({nm, " ready"}, 128'(s_ready), 128'(0));
        check({nm, " pulse"}, 128'(commit_pulse), 128'(0));
        check({nm, " busy"}, 128'(settle_busy), 128'(0));
        check({nm, " err"}, 128'(frame_err), 128'(0));
    endtask

    initial begin
        vec_t   vecs [8];
        frame_t f, f2;

        vecs[0] = '{"good",       L,     L,     1'b0, 1'b0, 1'b1};
        vecs[1] = '{"early20",    20,    20,    1'b0, 1'b0, 1'b0};
        vecs[2] = '{"gaps_good",  L,     L,     1'b1, 1'b0, 1'b1};
        vecs[3] = '{"no_last",    L,     0,     1'b0, 1'b0, 1'b0};
        vecs[4] = '{"one_byte",   1,     1,     1'b0, 1'b0, 1'b0};
        vecs[5] = '{"gaps_good2", L,     L,     1'b1, 1'b0, 1'b1};
        vecs[6] = '{"one_short",  L - 1, L - 1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{"bad_chk",    L,     L,     1'b0, 1'b1, !CHK};

        for (int i = 0; i < FRAME_LEN; i++) exp_act[i] = '0;

        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 128'(s_ready), 128'(1));

        fill_frame(f, 1, 1'b0);
        send_frame(f, L, L, 1'b0);
        check_commit("ramp", f, 1'b1);
        check("ramp a1", 128'(a_tmpl[7:0]), 128'(1));
        check("ramp i16", 128'(i_bias[127:120]), 128'(50));

        fill_frame(f, 0, 1'b0);
        fill_frame(f2, 0, 1'b0);
        send_frame(f, L, L, 1'b0);
        fork
            check_commit("back1", f, 1'b1);
            send_frame(f2, L, L, 1'b0);
        join
        check_commit("back2", f2, 1'b1);

        for (int v = 0; v < 8; v++) begin
            fill_frame(f, 0, vecs[v].bad_chk);
            send_frame(f, vecs[v].n, vecs[v].last_at, vecs[v].gaps);
            check_commit(vecs[v].name, f, vecs[v].exp_commit);
        end

        fill_frame(f, 0, 1'b0);
        send_frame(f, 20, 0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_load");
        @(negedge clk);
        rst_n = 1'b1;
        fill_frame(f, 0, 1'b0);
        send_frame(f, L, L, 1'b1);
        check_commit("after_rst_load", f, 1'b1);

        fill_frame(f, 0, 1'b0);
        send_frame(f, L, L, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("mid_settle_busy", 128'(settle_busy), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_settle");
        @(negedge clk);
        rst_n = 1'b1;
        fill_frame(f, 0, 1'b0);
        send_frame(f, L, L, 1'b0);
        check_commit("after_rst_settle", f, 1'b1);

`ifdef CNN_LOADER_CHECKSUM_EN
        fill_frame(f, 2, 1'b0);
        check("chk_byte_good", 128'(f[FRAME_LEN]), 128'(8'hFA));
        send_frame(f, L, L, 1'b0);
        check_commit("fives_ok", f, 1'b1);
        fill_frame(f, 2, 1'b1);
        send_frame(f, L, L, 1'b0);
        check_commit("fives_bad", f, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
